// File: rtl/pf_ddr4_dly_pkg.sv
// Shared types and constants for the DDR4 lane DQS delay-line move sequencer.
package pf_ddr4_dly_pkg;

    localparam int CNT_W = 8;

    localparam logic SEL_RX  = 1'b0;
    localparam logic SEL_TX  = 1'b1;
    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_MOVE       = 3'd2,
        ST_GAP        = 3'd3,
        ST_PAUSE_PRE  = 3'd4,
        ST_LOAD       = 3'd5,
        ST_PAUSE_POST = 3'd6,
        ST_DONE       = 3'd7
    } dly_state_t;

endpackage

// File: rtl/pf_ddr4_dly_gap_cnt.sv
// Loadable down-counter; 'last' flags the final cycle of a timed wait.
// Loading L-1 yields exactly L cycles in the following state.
module pf_ddr4_dly_gap_cnt
    import pf_ddr4_dly_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt_r;

    // Count down to zero after each load, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pf_ddr4_lane_dly_move_seq.sv
// Sequences tap moves and loads for one DDR4 lane's RX/TX DQS delay lines,
// tracking tap position per line and pausing HS_IO_CLK around loads.
module pf_ddr4_lane_dly_move_seq
    import pf_ddr4_dly_pkg::*;
#(
    parameter int DLY_W       = 8,
    parameter int TAP_MAX     = 255,
    parameter int LOAD_VAL    = 1,
    parameter int MOVE_GAP    = 4,
    parameter int PAUSE_LEAD  = 2,
    parameter int PAUSE_TRAIL = 2
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_LOAD,
    input  logic             REQ_SEL,
    input  logic             REQ_DIR,
    input  logic [DLY_W-1:0] REQ_COUNT,
    output logic             DONE,
    output logic             DONE_OOR,
    output logic [DLY_W-1:0] TAP_POS_RX,
    output logic [DLY_W-1:0] TAP_POS_TX,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_LOAD,
    output logic             HS_IO_CLK_PAUSE,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

    localparam logic [DLY_W-1:0] TAP_MAX_V  = DLY_W'(TAP_MAX);
    localparam logic [DLY_W-1:0] LOAD_VAL_V = DLY_W'(LOAD_VAL);
    localparam logic [DLY_W-1:0] ZERO_V     = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] ONE_V      = {{(DLY_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] GAP_LD_V   = CNT_W'(MOVE_GAP - 1);
    localparam logic [CNT_W-1:0] LEAD_LD_V  = CNT_W'(PAUSE_LEAD - 1);
    localparam logic [CNT_W-1:0] TRAIL_LD_V = CNT_W'(PAUSE_TRAIL - 1);

    dly_state_t       state_r;
    dly_state_t       state_nxt_s;
    logic             ready_r;
    logic             done_r;
    logic             done_oor_r;
    logic             move_r;
    logic             load_pulse_r;
    logic             pause_r;
    logic             sel_r;
    logic             dir_r;
    logic             is_load_r;
    logic [DLY_W-1:0] rem_r;
    logic [DLY_W-1:0] tap_rx_r;
    logic [DLY_W-1:0] tap_tx_r;
    logic [DLY_W-1:0] tap_sel_s;
    logic             range_bad_s;
    logic             flag_sel_s;
    logic             done_oor_nxt_s;
    logic             gap_load_s;
    logic [CNT_W-1:0] gap_val_s;
    logic             gap_last_s;

    assign tap_sel_s   = (sel_r == SEL_TX) ? tap_tx_r : tap_rx_r;
    assign range_bad_s = (dir_r == DIR_INC) ? (tap_sel_s == TAP_MAX_V) : (tap_sel_s == ZERO_V);
    assign flag_sel_s  = (sel_r == SEL_TX) ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

    pf_ddr4_dly_gap_cnt #(.W(CNT_W)) u_gap_cnt (
        .clk      (FAB_CLK),
        .rst_n    (RESET_N),
        .load     (gap_load_s),
        .load_val (gap_val_s),
        .last     (gap_last_s)
    );

    // Next-state decode; range is re-checked before every pulse so a move never leaves the legal span.
    always_comb begin
        state_nxt_s    = state_r;
        done_oor_nxt_s = 1'b0;
        gap_load_s     = 1'b0;
        gap_val_s      = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (is_load_r) begin
                    state_nxt_s = ST_PAUSE_PRE;
                    gap_load_s  = 1'b1;
                    gap_val_s   = LEAD_LD_V;
                end else if (rem_r == ZERO_V) begin
                    state_nxt_s = ST_DONE;
                end else if (range_bad_s) begin
                    state_nxt_s    = ST_DONE;
                    done_oor_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_MOVE;
                end
            end
            ST_MOVE: begin
                state_nxt_s = ST_GAP;
                gap_load_s  = 1'b1;
                gap_val_s   = GAP_LD_V;
            end
            ST_GAP: begin
                if (!gap_last_s) begin
                    state_nxt_s = ST_GAP;
                end else if (flag_sel_s) begin
                    state_nxt_s    = ST_DONE;
                    done_oor_nxt_s = 1'b1;
                end else if (rem_r == ZERO_V) begin
                    state_nxt_s = ST_DONE;
                end else if (range_bad_s) begin
                    state_nxt_s    = ST_DONE;
                    done_oor_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_MOVE;
                end
            end
            ST_PAUSE_PRE: begin
                if (gap_last_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_PAUSE_PRE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_PAUSE_POST;
                gap_load_s  = 1'b1;
                gap_val_s   = TRAIL_LD_V;
            end
            ST_PAUSE_POST: begin
                if (gap_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PAUSE_POST;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered strobes decoded from the next state so they align with the state they belong to.
    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ready_r      <= 1'b1;
            done_r       <= 1'b0;
            done_oor_r   <= 1'b0;
            move_r       <= 1'b0;
            load_pulse_r <= 1'b0;
            pause_r      <= 1'b0;
        end else begin
            ready_r      <= (state_nxt_s == ST_IDLE);
            done_r       <= (state_nxt_s == ST_DONE);
            done_oor_r   <= (state_nxt_s == ST_DONE) & done_oor_nxt_s;
            move_r       <= (state_nxt_s == ST_MOVE);
            load_pulse_r <= (state_nxt_s == ST_LOAD);
            pause_r      <= (state_nxt_s == ST_PAUSE_PRE) || (state_nxt_s == ST_LOAD) ||
                            (state_nxt_s == ST_PAUSE_POST);
        end
    end

    // Request latch and remaining-step counter.
    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_r     <= SEL_RX;
            dir_r     <= DIR_DEC;
            is_load_r <= 1'b0;
            rem_r     <= ZERO_V;
        end else if ((state_r == ST_IDLE) && REQ_VALID) begin
            sel_r     <= REQ_SEL;
            dir_r     <= REQ_DIR;
            is_load_r <= REQ_LOAD;
            rem_r     <= REQ_COUNT;
        end else if (state_r == ST_MOVE) begin
            rem_r <= rem_r - ONE_V;
        end else begin
            rem_r <= rem_r;
        end
    end

    // Tap tracking: step after each issued pulse, snap to LOAD_VAL as the LOAD pulse goes out.
    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tap_rx_r <= LOAD_VAL_V;
            tap_tx_r <= LOAD_VAL_V;
        end else if (state_r == ST_MOVE) begin
            if (sel_r == SEL_TX) begin
                tap_tx_r <= (dir_r == DIR_INC) ? tap_tx_r + ONE_V : tap_tx_r - ONE_V;
            end else begin
                tap_rx_r <= (dir_r == DIR_INC) ? tap_rx_r + ONE_V : tap_rx_r - ONE_V;
            end
        end else if (state_nxt_s == ST_LOAD) begin
            if (sel_r == SEL_TX) begin
                tap_tx_r <= LOAD_VAL_V;
            end else begin
                tap_rx_r <= LOAD_VAL_V;
            end
        end else begin
            tap_rx_r <= tap_rx_r;
            tap_tx_r <= tap_tx_r;
        end
    end

    assign REQ_READY            = ready_r;
    assign DONE                 = done_r;
    assign DONE_OOR             = done_oor_r;
    assign TAP_POS_RX           = tap_rx_r;
    assign TAP_POS_TX           = tap_tx_r;
    assign DELAY_LINE_SEL       = sel_r;
    assign DELAY_LINE_DIRECTION = dir_r;
    assign DELAY_LINE_MOVE      = move_r;
    assign DELAY_LINE_LOAD      = load_pulse_r;
    assign HS_IO_CLK_PAUSE      = pause_r;

endmodule
